hifq_read_sequencer: RTL

- Controller for the high-frequency 1536x16 circular sample queue, built on the dual-port RAM with a 1-cycle read latency.
- Owns the write pointer and fill count.
- On each new sample, once enough history exists, drives the RAM read port through the newest TAPS samples, oldest first, and flags that window for the downstream FIR MAC.
- Sits between the sample source (wrt_smpl strobe) and the FIR accumulator.

---
 rtl/hifq_read_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/hifq_read_sequencer.sv
// Purpose: write pointer, fill count and read-window sequencer for the 1536x16 HF sample queue (optional HIFQ_OVERRUN_CNT_EN adds ovr_cnt).
// Latency: window starts 2 cycles after the triggering strobe; sequencing is aligned to the 1-cycle RAM read data.
// Backpressure: none, writes are never stalled; a strobe arriving while a follow-on window is already queued pulses overrun.
module hifq_read_sequencer #(
    parameter int DEPTH = 1536,
    parameter int TAPS  = 1021,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wrt_smpl,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [AW-1:0] raddr,
    output logic          sequencing,
    output logic          seq_first,
    output logic          seq_last,
    output logic          seq_done,
    output logic          full,
    output logic          overrun
`ifdef HIFQ_OVERRUN_CNT_EN
    ,
    output logic [7:0]    ovr_cnt
`endif
);

    localparam int CW = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [AW-1:0] r_raddr, r_rd_cnt, w_start;
    logic [CW-1:0] r_cnt, w_cnt_inc, w_start_sum;
    logic          r_pending, w_start_seq, w_busy, w_overrun;
    logic          r_seq_vld, r_seq_first, r_seq_last, r_seq_done, r_overrun;

    assign w_wr_ptr_nxt = !wrt_smpl ? r_wr_ptr :
                          (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_cnt_inc    = r_cnt + 1'b1;

    // Window start is (post-write pointer - TAPS) mod DEPTH, done as an add of DEPTH-TAPS.
    assign w_start_sum  = {1'b0, w_wr_ptr_nxt} + CW'(DEPTH - TAPS);
    assign w_start      = (w_start_sum >= CW'(DEPTH)) ? AW'(w_start_sum - CW'(DEPTH))
                                                      : w_start_sum[AW-1:0];

    assign w_busy       = (r_state != ST_IDLE);
    assign w_overrun    = wrt_smpl && w_busy && r_pending;

    always_comb begin
        w_state_nxt = r_state;
        w_start_seq = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((wrt_smpl && (w_cnt_inc >= CW'(TAPS))) || r_pending) begin
                    w_state_nxt = ST_RUN;
                    w_start_seq = 1'b1;
                end
            end
            ST_RUN:   if (r_rd_cnt == AW'(TAPS - 1)) w_state_nxt = ST_DRAIN;
            ST_DRAIN: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
            r_raddr     <= '0;
            r_rd_cnt    <= '0;
            r_pending   <= 1'b0;
            r_seq_vld   <= 1'b0;
            r_seq_first <= 1'b0;
            r_seq_last  <= 1'b0;
            r_seq_done  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (wrt_smpl) begin
                r_wr_ptr <= w_wr_ptr_nxt;
                if (r_cnt != CW'(DEPTH)) r_cnt <= w_cnt_inc;
            end
            if (w_start_seq) begin
                r_raddr  <= w_start;
                r_rd_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                r_raddr  <= (r_raddr == AW'(DEPTH - 1)) ? '0 : r_raddr + 1'b1;
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            // A strobe while busy queues exactly one follow-on window.
            if (wrt_smpl && w_busy)
                r_pending <= 1'b1;
            else if (w_start_seq)
                r_pending <= 1'b0;
            r_seq_vld   <= (r_state == ST_RUN);
            r_seq_first <= (r_state == ST_RUN) && (r_rd_cnt == '0);
            r_seq_last  <= (r_state == ST_RUN) && (r_rd_cnt == AW'(TAPS - 1));
            r_seq_done  <= r_seq_last;
            r_overrun   <= w_overrun;
        end
    end

`ifdef HIFQ_OVERRUN_CNT_EN
    logic [7:0] r_ovr_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_ovr_cnt <= '0;
        else if (w_overrun && (r_ovr_cnt != 8'hFF))
            r_ovr_cnt <= r_ovr_cnt + 1'b1;
    end

    assign ovr_cnt = r_ovr_cnt;
`endif

    assign we         = wrt_smpl;
    assign waddr      = r_wr_ptr;
    assign raddr      = r_raddr;
    assign sequencing = r_seq_vld;
    assign seq_first  = r_seq_first;
    assign seq_last   = r_seq_last;
    assign seq_done   = r_seq_done;
    assign full       = (r_cnt == CW'(DEPTH));
    assign overrun    = r_overrun;

endmodule
